// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the (39,32) SECDED encoder/decoder pair.
//   - width constants for data, codeword, parity and syndrome
//   - is_parity_pos(p): 1 when 1-based position p holds a Hamming bit
//   - extract_data(code): gather the 32 data bits from a codeword
//   - ecc_status_t: per-word decode classification
package ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CODE_W = 39;
  localparam int PAR_W  = 7;
  localparam int SYN_W  = PAR_W - 1;  // overall parity bit is not part of s

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } ecc_status_t;

  // Hamming bits live at the power-of-two positions 1,2,4,...,32.
  function automatic logic is_parity_pos(input logic [5:0] p);
    return (p != 6'd0) && ((p & (p - 6'd1)) == 6'd0);
  endfunction

  // Data bits occupy the non-power-of-two positions 3..38, ascending, LSB first.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if (!is_parity_pos(6'(p))) begin
        d[j[4:0]] = code[6'(p-1)];
        j++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome generator for the (39,32) code.
//   i_code [38:0] : codeword, position p (1..38) at bit p-1, overall parity at bit 38
//   o_syn  [5:0]  : Hamming syndrome, bit k = XOR of positions whose index has bit k set
//   o_pe          : XOR of all 39 bits
module ecc_syndrome
  import ecc_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SYN_W-1:0]  o_syn,
  output logic              o_pe
);

  always_comb begin
    o_syn = '0;
    for (int k = 0; k < SYN_W; k++) begin
      for (int p = 1; p < CODE_W; p++) begin
        if (((p >> k) & 1) == 1) o_syn[k] = o_syn[k] ^ i_code[6'(p-1)];
      end
    end
  end

  assign o_pe = ^i_code;

endmodule

// File: rtl/ecc_decode.sv
// ecc_decode: two-stage SECDED decoder with saturating error counters and a
// first-error log.
//   clk, rst          : clock, synchronous active-high reset
//   code_valid/code_in: received 39-bit codeword
//   data_valid        : outputs below valid (2 cycles after code_valid)
//   data_out          : corrected data (uncorrected extraction on ded_err)
//   sec_err / ded_err : single corrected / uncorrectable flags
//   syndrome          : Hamming syndrome of the output word
//   cnt_clr           : clears counters and log; wins over a same-cycle error
//   sec_cnt / ded_cnt : saturating error counts
//   log_valid, log_syndrome, log_ded : first error since clear/reset
module ecc_decode
  import ecc_pkg::*;
#(
  parameter int P_DATAWIDTH   = 32,
  parameter int P_CODEWIDTH   = 39,
  parameter int P_PARITYWIDTH = 7,
  parameter int P_CNTWIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       code_valid,
  input  logic [P_CODEWIDTH-1:0]     code_in,
  output logic                       data_valid,
  output logic [P_DATAWIDTH-1:0]     data_out,
  output logic                       sec_err,
  output logic                       ded_err,
  output logic [P_PARITYWIDTH-2:0]   syndrome,
  input  logic                       cnt_clr,
  output logic [P_CNTWIDTH-1:0]      sec_cnt,
  output logic [P_CNTWIDTH-1:0]      ded_cnt,
  output logic                       log_valid,
  output logic [P_PARITYWIDTH-2:0]   log_syndrome,
  output logic                       log_ded
);

  // vld_pipe[0]: stage-1 word valid, vld_pipe[1]: output word valid
  logic [1:0]              r_vld_pipe;
  logic [CODE_W-1:0]       r_code;
  logic [SYN_W-1:0]        r_syn;
  logic                    r_pe;

  logic [SYN_W-1:0]        w_syn;
  logic                    w_pe;
  ecc_status_t             w_status;
  logic [CODE_W-1:0]       w_fix;
  logic [DATA_W-1:0]       w_data;

  logic [DATA_W-1:0]       r_data;
  logic [SYN_W-1:0]        r_syn_out;
  logic                    r_sec;
  logic                    r_ded;
  logic [P_CNTWIDTH-1:0]   r_sec_cnt;
  logic [P_CNTWIDTH-1:0]   r_ded_cnt;
  logic                    r_log_valid;
  logic [SYN_W-1:0]        r_log_syn;
  logic                    r_log_ded;

  ecc_syndrome u_syn (
    .i_code (code_in),
    .o_syn  (w_syn),
    .o_pe   (w_pe)
  );

  // Stage 1: capture codeword with its syndrome and overall parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe[0] <= 1'b0;
      r_code        <= '0;
      r_syn         <= '0;
      r_pe          <= 1'b0;
    end else begin
      r_vld_pipe[0] <= code_valid;
      r_code        <= code_in;
      r_syn         <= w_syn;
      r_pe          <= w_pe;
    end
  end

  // Classification and correction. s=0/pe=1 means only bit 38 flipped, so
  // the data bits need no fix. Syndromes past position 38 with odd parity
  // cannot come from a single error and are treated as uncorrectable.
  always_comb begin
    w_fix    = r_code;
    w_status = CLEAN;
    if (r_syn == '0) begin
      w_status = r_pe ? SEC : CLEAN;
    end else if (!r_pe || (r_syn > 6'(P_CODEWIDTH - 1))) begin
      w_status = DED;
    end else begin
      w_status            = SEC;
      w_fix[r_syn - 6'd1] = ~r_code[r_syn - 6'd1];
    end
    w_data = extract_data(w_fix);
  end

  // Stage 2: output register. Data/syndrome hold when no word arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe[1] <= 1'b0;
      r_data        <= '0;
      r_syn_out     <= '0;
      r_sec         <= 1'b0;
      r_ded         <= 1'b0;
    end else begin
      r_vld_pipe[1] <= r_vld_pipe[0];
      r_sec         <= r_vld_pipe[0] && (w_status == SEC);
      r_ded         <= r_vld_pipe[0] && (w_status == DED);
      if (r_vld_pipe[0]) begin
        r_data    <= w_data;
        r_syn_out <= r_syn;
      end
    end
  end

  // Statistics follow the presented output word; clear beats counting.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_sec_cnt   <= '0;
      r_ded_cnt   <= '0;
      r_log_valid <= 1'b0;
      r_log_syn   <= '0;
      r_log_ded   <= 1'b0;
    end else if (r_vld_pipe[1]) begin
      if (r_sec && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + P_CNTWIDTH'(1);
      if (r_ded && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + P_CNTWIDTH'(1);
      if ((r_sec || r_ded) && !r_log_valid) begin
        r_log_valid <= 1'b1;
        r_log_syn   <= r_syn_out;
        r_log_ded   <= r_ded;
      end
    end
  end

  assign data_valid   = r_vld_pipe[1];
  assign data_out     = r_data;
  assign sec_err      = r_sec;
  assign ded_err      = r_ded;
  assign syndrome     = r_syn_out;
  assign sec_cnt      = r_sec_cnt;
  assign ded_cnt      = r_ded_cnt;
  assign log_valid    = r_log_valid;
  assign log_syndrome = r_log_syn;
  assign log_ded      = r_log_ded;

endmodule

// File: tb/tb_ecc_decode.sv
// tb_ecc_decode: directed test-plan cases plus random traffic, checked every
// cycle against a position-arithmetic reference model of the SECDED code.
module tb_ecc_decode;

  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, code_valid, cnt_clr;
  logic [38:0]   code_in;
  logic          data_valid, sec_err, ded_err, log_valid, log_ded;
  logic [31:0]   data_out;
  logic [5:0]    syndrome, log_syndrome;
  logic [CW-1:0] sec_cnt, ded_cnt;

  int n_chk = 0;
  int n_err = 0;

  // reference state
  logic        s1_v;
  logic [38:0] s1_code;
  logic        m_v, m_sec, m_ded;
  logic [31:0] m_data;
  int          m_syn;
  int          m_sec_cnt, m_ded_cnt, m_lsyn;
  logic        m_lv, m_lded;

  always #5 clk = ~clk;

  ecc_decode #(.P_CNTWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_in(code_in),
    .data_valid(data_valid), .data_out(data_out), .sec_err(sec_err),
    .ded_err(ded_err), .syndrome(syndrome), .cnt_clr(cnt_clr),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .log_valid(log_valid),
    .log_syndrome(log_syndrome), .log_ded(log_ded)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [38:0] c);
    logic [31:0] d = '0;
    int j = 0;
    for (int p = 1; p <= 38; p++)
      if (!is_pow2(p)) begin d[j[4:0]] = c[6'(p-1)]; j++; end
    return d;
  endfunction

  // Syndrome as the XOR of the positions of all set bits.
  function automatic int ref_syn(input logic [38:0] c);
    int s = 0;
    for (int p = 1; p <= 38; p++) if (c[6'(p-1)]) s ^= p;
    return s;
  endfunction

  function automatic logic [38:0] ref_enc(input logic [31:0] d);
    logic [38:0] c = '0;
    int j = 0, s;
    for (int p = 1; p <= 38; p++)
      if (!is_pow2(p)) begin c[6'(p-1)] = d[j[4:0]]; j++; end
    s = ref_syn(c);
    for (int k = 0; k < 6; k++) c[6'((1 << k) - 1)] = s[k];
    c[38] = ^c[37:0];
    return c;
  endfunction

  task automatic ref_dec(input logic [38:0] c, output logic [31:0] d, output int s,
                         output logic sec, output logic ded);
    logic [38:0] f = c;
    logic pe = ^c;
    s = ref_syn(c);
    sec = 0; ded = 0;
    if (s == 0) sec = pe;
    else if (pe && s <= 38) begin sec = 1; f[6'(s-1)] = ~f[6'(s-1)]; end
    else ded = 1;
    d = ref_extract(f);
  endtask

  task automatic model_reset();
    s1_v = 0; s1_code = '0; m_v = 0; m_sec = 0; m_ded = 0; m_data = '0; m_syn = 0;
    m_sec_cnt = 0; m_ded_cnt = 0; m_lv = 0; m_lsyn = 0; m_lded = 0;
  endtask

  // One clock: drive inputs, advance the reference, compare every output.
  task automatic step(input logic v, input logic [38:0] c, input logic clr, input logic r);
    logic [31:0] d; int s; logic sec, ded;
    code_valid = v; code_in = c; cnt_clr = clr; rst = r;
    @(posedge clk); #1;
    if (r) model_reset();
    else begin
      if (clr) begin
        m_sec_cnt = 0; m_ded_cnt = 0; m_lv = 0; m_lsyn = 0; m_lded = 0;
      end else if (m_v) begin
        if (m_sec && m_sec_cnt < MAX) m_sec_cnt++;
        if (m_ded && m_ded_cnt < MAX) m_ded_cnt++;
        if ((m_sec || m_ded) && !m_lv) begin m_lv = 1; m_lsyn = m_syn; m_lded = m_ded; end
      end
      m_v = s1_v; m_sec = 0; m_ded = 0;
      if (s1_v) begin
        ref_dec(s1_code, d, s, sec, ded);
        m_data = d; m_syn = s; m_sec = sec; m_ded = ded;
      end
      s1_v = v; s1_code = c;
    end
    chk("data_valid", {31'd0, data_valid}, {31'd0, m_v});
    chk("data_out", data_out, m_data);
    chk("sec_err", {31'd0, sec_err}, {31'd0, m_sec});
    chk("ded_err", {31'd0, ded_err}, {31'd0, m_ded});
    chk("syndrome", {26'd0, syndrome}, m_syn);
    chk("sec_cnt", {30'd0, sec_cnt}, m_sec_cnt);
    chk("ded_cnt", {30'd0, ded_cnt}, m_ded_cnt);
    chk("log_valid", {31'd0, log_valid}, {31'd0, m_lv});
    chk("log_syndrome", {26'd0, log_syndrome}, m_lsyn);
    chk("log_ded", {31'd0, log_ded}, {31'd0, m_lded});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [38:0] cw, c;
  int          b1, b2;

  initial begin
    model_reset();
    code_valid = 0; code_in = '0; cnt_clr = 0; rst = 1;
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk("rst_outputs", {data_valid, sec_err, ded_err, log_valid, data_out[0]}, '0);

    cw = ref_enc(32'hDEADBEEF);

    // clean word
    step(1, cw, 0, 0); idle(1);
    chk("clean_data", data_out, 32'hDEADBEEF);
    chk("clean_flags", {30'd0, sec_err, ded_err}, 0);
    idle(1);
    chk("clean_cnt", {30'd0, sec_cnt}, 0);

    // data bit error at position 3
    step(1, cw ^ (39'd1 << 2), 0, 0); idle(1);
    chk("sec_data", data_out, 32'hDEADBEEF);
    chk("sec_syn", {26'd0, syndrome}, 3);
    idle(1);
    chk("sec_cnt1", {30'd0, sec_cnt}, 1);
    chk("sec_log", {25'd0, log_valid, log_syndrome, log_ded}, {25'd0, 1'b1, 6'd3, 1'b0});

    // parity bit errors
    step(1, cw ^ (39'd1 << 38), 0, 0); idle(1);
    chk("p38_syn", {25'd0, sec_err, syndrome}, {25'd0, 1'b1, 6'd0});
    step(1, cw ^ (39'd1 << 31), 0, 0); idle(1);
    chk("p31_syn", {25'd0, sec_err, syndrome}, {25'd0, 1'b1, 6'd32});

    // double error
    c = cw ^ (39'd1 << 2) ^ (39'd1 << 4);
    step(1, c, 0, 0); idle(1);
    chk("ded_syn", {25'd0, ded_err, syndrome}, {25'd0, 1'b1, 6'd6});
    chk("ded_data", data_out, ref_extract(c));
    idle(1);
    chk("ded_cnt1", {30'd0, ded_cnt}, 1);
    step(1, cw ^ (39'd1 << 7) ^ (39'd1 << 20), 0, 0); idle(2);
    chk("log_kept", {25'd0, log_valid, log_syndrome, log_ded}, {25'd0, 1'b1, 6'd3, 1'b0});

    // saturation with 5 back-to-back single errors
    for (int i = 0; i < 5; i++) step(1, cw ^ (39'd1 << (i + 8)), 0, 0);
    idle(3);
    chk("sec_sat", {30'd0, sec_cnt}, MAX);

    // clear in the same cycle as an error output
    step(1, cw ^ (39'd1 << 9), 0, 0); idle(1);
    step(0, '0, 1, 0);
    chk("clr_cnt", {30'd0, sec_cnt}, 0);
    chk("clr_log", {31'd0, log_valid}, 0);

    // reset mid-stream
    step(1, cw ^ (39'd1 << 5), 0, 0);
    step(0, '0, 0, 1);
    idle(3);
    chk("rst_mid", {data_valid, sec_err, ded_err, data_out[0], 1'b0} , '0);
    chk("rst_mid_data", data_out, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      c  = ref_enc($urandom);
      b1 = $urandom_range(38);
      b2 = (b1 + 1 + $urandom_range(37)) % 39;
      case ($urandom_range(3))
        1: c[6'(b1)] = ~c[6'(b1)];
        2: begin c[6'(b1)] = ~c[6'(b1)]; c[6'(b2)] = ~c[6'(b2)]; end
        3: c = {$urandom, $urandom} & 39'h7F_FFFF_FFFF;
        default: ;
      endcase
      step(($urandom_range(3) != 0), c, ($urandom_range(24) == 0), ($urandom_range(60) == 0));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
